// File: rtl/multi_channel_combiner.sv
// Purpose: register-mapped combiner; pops one word from each of NCH input FIFOs and pushes OR/AND/XOR/ADD of them into an output FIFO.
// Latency: with delay=0 a result is readable two cycles after the last channel write; results are spaced at least delay+1 cycles apart.
// Backpressure: fires only when all channels hold data and y has space; writes to a full channel are dropped and flagged as overflow.
//
// Ports:
//   CLK, RST                              rising-edge clock, synchronous active-high reset
//   write_address/write_data/write_en     register write port (3 mode, 4 delay, 5 status W1C, 8+i channel i)
//   read_address/read_en/read_data        register read port (combinational mux; read_en at address 2 pops y)
//   write_rdy, read_rdy                   always 1
module multi_channel_combiner #(
  parameter int WIDTH     = 8,
  parameter int NCH       = 2,
  parameter int IN_DEPTH  = 2,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 8,
  parameter int DELAY_RST = 50
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_en,
  output logic             write_rdy,
  input  logic [3:0]       read_address,
  input  logic             read_en,
  output logic [WIDTH-1:0] read_data,
  output logic             read_rdy
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  // Per-channel input FIFOs: storage, pointers and occupancy.
  logic [WIDTH-1:0] ch_mem [NCH][IN_DEPTH];
  logic [IAW-1:0]   ch_wp  [NCH];
  logic [IAW-1:0]   ch_rp  [NCH];
  logic [IAW:0]     ch_cnt [NCH];

  // Output FIFO.
  logic [WIDTH-1:0] y_mem [OUT_DEPTH];
  logic [OAW-1:0]   y_wp, y_rp;
  logic [OAW:0]     y_cnt;

  logic [1:0]       mode;
  logic [CNT_W-1:0] delay, cnt;
  logic             ovf, udf;

  logic [NCH-1:0]   full_n, empty_n, ch_enq;
  logic             y_empty_n, y_full, y_pop, fire, ovf_evt, udf_evt, st_clr;
  logic [WIDTH-1:0] y_head, comb_res;

  assign write_rdy = 1'b1;
  assign read_rdy  = 1'b1;

  always_comb begin
    full_n  = '0;
    empty_n = '0;
    for (int i = 0; i < NCH; i++) begin
      full_n[i]  = (ch_cnt[i] != (IAW+1)'(IN_DEPTH));
      empty_n[i] = (ch_cnt[i] != '0);
    end
  end

  // Channel enqueue decode; acceptance uses start-of-cycle fullness, so a
  // full FIFO drops the write even if fire drains it in the same cycle.
  always_comb begin
    ch_enq  = '0;
    ovf_evt = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (write_en && (write_address == 4'(8 + i))) begin
        if (full_n[i]) ch_enq[i] = 1'b1;
        else           ovf_evt   = 1'b1;
      end
    end
  end

  assign st_clr    = write_en && (write_address == 4'd5);
  assign y_empty_n = (y_cnt != '0);
  assign y_full    = (y_cnt == (OAW+1)'(OUT_DEPTH));
  assign y_head    = y_mem[y_rp];
  assign y_pop     = read_en && (read_address == 4'd2) && y_empty_n;
  assign udf_evt   = read_en && (read_address == 4'd2) && !y_empty_n;
  assign fire      = (cnt >= delay) && (&empty_n) && !y_full;

  // Combine the channel heads with the registered mode, so a mode write in
  // the firing cycle only affects later fires.
  always_comb begin
    comb_res = ch_mem[0][ch_rp[0]];
    for (int i = 1; i < NCH; i++) begin
      case (mode)
        2'd0:    comb_res = comb_res | ch_mem[i][ch_rp[i]];
        2'd1:    comb_res = comb_res & ch_mem[i][ch_rp[i]];
        2'd2:    comb_res = comb_res ^ ch_mem[i][ch_rp[i]];
        default: comb_res = comb_res + ch_mem[i][ch_rp[i]];
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        ch_wp[i]  <= '0;
        ch_rp[i]  <= '0;
        ch_cnt[i] <= '0;
      end
      y_wp  <= '0;
      y_rp  <= '0;
      y_cnt <= '0;
      mode  <= 2'd0;
      delay <= CNT_W'(DELAY_RST);
      cnt   <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_enq[i]) ch_wp[i] <= ch_wp[i] + IAW'(1);
        if (fire)      ch_rp[i] <= ch_rp[i] + IAW'(1);
        ch_cnt[i] <= ch_cnt[i] + (IAW+1)'(ch_enq[i]) - (IAW+1)'(fire);
      end
      if (fire)  y_wp <= y_wp + OAW'(1);
      if (y_pop) y_rp <= y_rp + OAW'(1);
      y_cnt <= y_cnt + (OAW+1)'(fire) - (OAW+1)'(y_pop);

      if (write_en && (write_address == 4'd3)) mode  <= write_data[1:0];
      if (write_en && (write_address == 4'd4)) delay <= CNT_W'(write_data);

      // Saturating interval counter; a fire restarts the interval.
      if (fire)              cnt <= '0;
      else if (cnt < delay)  cnt <= cnt + CNT_W'(1);

      // New events take priority over a same-cycle clear.
      ovf <= ovf_evt | (ovf & ~(st_clr & write_data[0]));
      udf <= udf_evt | (udf & ~(st_clr & write_data[1]));
    end
  end

  // Storage needs no reset: occupancy counters gate every read of it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_enq[i]) ch_mem[i][ch_wp[i]] <= write_data;
      end
      if (fire) y_mem[y_wp] <= comb_res;
    end
  end

  always_comb begin
    read_data = '0;
    case (read_address)
      4'd0:    read_data = WIDTH'(full_n);
      4'd1:    read_data = WIDTH'(y_empty_n);
      4'd2:    read_data = y_empty_n ? y_head : '0;
      4'd3:    read_data = WIDTH'(mode);
      4'd4:    read_data = WIDTH'(delay);
      4'd5:    read_data = WIDTH'({udf, ovf});
      4'd6:    read_data = WIDTH'(empty_n);
      default: read_data = '0;
    endcase
  end

endmodule

// File: doc/multi_channel_combiner.md
# multi_channel_combiner

Parametrised register-mapped combiner, successor to the fixed two-input delayed OR unit. It accepts NCH input channels through a write port into per-channel FIFOs. Whenever every channel holds data, the output FIFO has space, and a programmable interval has elapsed, it pops one word from each channel and pushes the combined result (OR/AND/XOR/ADD) into an output FIFO drained through the read port. It sits on the same simple write/read register bus as the other test DUTs in the design.

## Interface
- WIDTH, 8: data width of every channel and of the result
- NCH, 2: number of input channels, legal 2..4
- IN_DEPTH, 2: depth of each input FIFO, power of 2, ≥2
- OUT_DEPTH, 2: depth of output FIFO, power of 2, ≥2
- CNT_W, 8: width of interval counter and delay register
- DELAY_RST, 50: reset value of delay register
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset; one clock; reset is synchronous and active-high
- write_address  in  4  write register select
- write_data  in  WIDTH  write payload
- write_en  in  1  write strobe, one write per cycle
- write_rdy  out  1  tied 1
- read_address  in  4  read register select
- read_en  in  1  read strobe; pops output FIFO only at address 2
- read_data  out  WIDTH  combinational read mux, zero-extended
- read_rdy  out  1  tied 1

## Operation
- Write map:
  - 3: mode[1:0] (0 OR, 1 AND, 2 XOR, 3 ADD mod 2^WIDTH).
  - 4: delay[CNT_W-1:0].
  - 5: write-1-to-clear status bits.
  - 8+i (i<NCH): enqueue channel i.
  - Other addresses are ignored.
- Read map:
  - 0: full_n vector, bit i = channel i not full.
  - 1: {0, y_empty_n}.
  - 2: y head, or 0 if empty.
  - 3: mode.
  - 4: delay.
  - 5: {0, underflow, overflow}.
  - 6: {0, empty_n vector}.
  - Others read 0.
- Enqueue to channel i is accepted only if that FIFO is not full at the start of the cycle. A write to a full channel is dropped and sets sticky overflow.
- read_en at address 2 pops y if non-empty. When y is empty the read returns 0 and sets sticky underflow.
- Interval counter cnt:
  - Increments each cycle while cnt < delay and saturates at delay.
  - fire = (cnt ≥ delay) & all channels non-empty & y not full, with every term evaluated on start-of-cycle state.
  - On fire: pop one word from every channel, push combine(heads) into y, and set cnt ← 0.
  - With delay = 0, fire may occur every cycle.
- Writing delay below the current cnt makes fire eligible on the next cycle.
- A mode write in the same cycle as fire: the fire uses the old mode.
- A status clear in the same cycle as a new overflow/underflow event: the event wins and the bit stays 1.
- No bypass in any FIFO:
  - A FIFO that is full at cycle start rejects enq even if it is dequeued that cycle.
  - An empty FIFO cannot be dequeued in the cycle it is written.

## Timing
- Reset values:
  - All FIFOs empty, so full_n all 1, y_empty_n 0.
  - cnt 0, mode 0, delay DELAY_RST, status 0.
  - read_data follows the map: address 0 reads all ones in NCH bits.
- Assertion of RST mid-operation discards all FIFO contents and sticky bits at the next edge; pending writes in that cycle are ignored.
- Latency with delay = 0:
  - All channels written by cycle t.
  - Heads visible at t+1, fire at t+1.
  - y_empty_n = 1 and address-2 data valid at t+2.
- Fire spacing: between consecutive fires at least delay+1 cycles when delay > 0 (cnt runs 0..delay), or 1 cycle when delay = 0.
- Throughput once the delay has elapsed: one result per fire.
- Pop at address 2 updates y_empty_n / head the following cycle.
- Back-to-back reads on consecutive cycles drain consecutive entries.

## Test plan
- Reset, then read addresses 0/1/4/5 -> 0b11, 0, 50, 0 (NCH=2).
- Mode 0, delay 50: write 0x0F to ch0 and 0xA0 to ch1 at cycle 1 -> no fire before cnt reaches 50; then y = 0xAF and an address-2 read returns 0xAF, with y_empty_n dropping the cycle after the pop.
- Delay 0, mode 3: push 0xF0+0x20 then 0x01+0x02 -> y reads 0x10 then 0x03 (wrap); results arrive one cycle apart.
- Fill ch0 (IN_DEPTH writes) plus one extra, with no writes to ch1 -> extra write dropped, full_n[0] = 0, overflow = 1, no fire. Write 1 to address 5 -> overflow cleared.
- Address-2 read with y empty -> read_data 0, underflow = 1, y state unchanged. Fill y to OUT_DEPTH with inputs pending -> fire stalls until one pop, then resumes next cycle.
- Assert RST with all FIFOs partly full and mode = 2 -> next cycle all reset values restored; stale data is never read back.
